// File: rtl/lfsr_rng_arbiter.sv
// Round-robin arbiter sharing one 8-bit Fibonacci LFSR among NUM_REQ requesters.
// Optional reseed port pair enabled by defining LFSR_RESEED_EN.
module lfsr_rng_arbiter #(
  parameter int         NUM_REQ = 4,
  parameter logic [7:0] SEED    = 8'd42,
  parameter int         STEPS   = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [7:0]         rnd_o,
  output logic               valid_o,
  input  logic               ack_i,
  output logic               busy_o
`ifdef LFSR_RESEED_EN
  ,
  input  logic [7:0]         seed_i,
  input  logic               seed_we_i
`endif
);

  localparam int         PW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0] SEED_INIT = (SEED == 8'd0) ? 8'h01 : SEED;
  localparam logic [7:0] CNT_INIT  = 8'(STEPS - 1);
  localparam logic [PW-1:0] LAST   = PW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STEP    = 2'd1,
    DELIVER = 2'd2
  } state_t;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

`ifdef LFSR_RESEED_EN
  // An all-zero seed would lock the LFSR, so it is replaced by 8'h01.
  function automatic logic [7:0] seed_fix(input logic [7:0] v);
    return (v == 8'd0) ? 8'h01 : v;
  endfunction
`endif

  state_t               state_r;
  logic [7:0]           lfsr_r;
  logic [7:0]           cnt_r;
  logic [NUM_REQ-1:0]   gnt_r;
  logic [PW-1:0]        win_r;
  logic [PW-1:0]        ptr_r;
  logic                 valid_r;
  logic                 busy_r;

  logic                 any_req_s;
  logic [PW-1:0]        win_s;
  logic [PW-1:0]        idx_s;
  logic                 hit_s;

  // Round-robin pick: first requesting index at or after ptr_r, wrapping.
  always_comb begin
    any_req_s = 1'b0;
    win_s     = '0;
    idx_s     = '0;
    hit_s     = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_s     = PW'((int'(ptr_r) + k) % NUM_REQ);
      hit_s     = !any_req_s && req_i[idx_s];
      win_s     = hit_s ? idx_s : win_s;
      any_req_s = any_req_s | hit_s;
    end
  end

  // Draw sequencer: grant, advance the LFSR STEPS times, then hold until ack.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= IDLE;
      lfsr_r  <= SEED_INIT;
      cnt_r   <= 8'd0;
      gnt_r   <= '0;
      win_r   <= '0;
      ptr_r   <= '0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
`ifdef LFSR_RESEED_EN
          if (seed_we_i) begin
            lfsr_r <= seed_fix(seed_i);
          end
`endif
          if (any_req_s) begin
            state_r <= STEP;
            gnt_r   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_s;
            win_r   <= win_s;
            cnt_r   <= CNT_INIT;
            busy_r  <= 1'b1;
          end
        end
        STEP: begin
          lfsr_r <= lfsr_next(lfsr_r);
          if (cnt_r == 8'd0) begin
            state_r <= DELIVER;
            valid_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r - 8'd1;
          end
        end
        DELIVER: begin
          if (ack_i) begin
            state_r <= IDLE;
            gnt_r   <= '0;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            ptr_r   <= (win_r == LAST) ? '0 : win_r + PW'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          gnt_r   <= '0;
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt_o   = gnt_r;
  assign rnd_o   = lfsr_r;
  assign valid_o = valid_r;
  assign busy_o  = busy_r;

endmodule

// File: tb/tb_lfsr_rng_arbiter.sv
// Scoreboard bench for lfsr_rng_arbiter: STEPS=1 instance for draws/round-robin,
// STEPS=8 instance for multi-step latency and reset during STEP.
module tb_lfsr_rng_arbiter;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, ack, valid, busy;
  logic [3:0] req, gnt;
  logic [7:0] rnd;
  logic       rst8, ack8, valid8, busy8;
  logic [3:0] req8, gnt8;
  logic [7:0] rnd8;
`ifdef LFSR_RESEED_EN
  logic [7:0] seed, seed8;
  logic       seed_we, seed_we8;
`endif

  lfsr_rng_arbiter #(.NUM_REQ(4), .SEED(8'd42), .STEPS(1)) dut (
`ifdef LFSR_RESEED_EN
    .seed_i(seed), .seed_we_i(seed_we),
`endif
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .rnd_o(rnd),
    .valid_o(valid), .ack_i(ack), .busy_o(busy)
  );

  lfsr_rng_arbiter #(.NUM_REQ(4), .SEED(8'd42), .STEPS(8)) dut8 (
`ifdef LFSR_RESEED_EN
    .seed_i(seed8), .seed_we_i(seed_we8),
`endif
    .clk_i(clk), .rst_i(rst8), .req_i(req8), .gnt_o(gnt8), .rnd_o(rnd8),
    .valid_o(valid8), .ack_i(ack8), .busy_o(busy8)
  );

  typedef struct packed {
    logic [3:0] gnt;
    logic [7:0] rnd;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  int   stamps_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic valid_q = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: each new delivery pops one expected {gnt, rnd} from the scoreboard.
  always @(negedge clk) begin
    if (valid === 1'b1 && valid_q !== 1'b1) begin
      stamps_q.push_back(cyc);
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_valid", 32'(valid), 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("sb_gnt", 32'(gnt), 32'(e.gnt));
        chk("sb_rnd", 32'(rnd), 32'(e.rnd));
      end
    end
    valid_q <= valid;
  end

  task automatic wait_valid(input int bound);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (valid !== 1'b1 && n < bound);
    if (valid !== 1'b1) chk("valid_timeout", 32'(valid), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 4'd0; ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; req = 4'd0; ack = 1'b0;
    rst8 = 1'b1; req8 = 4'd0; ack8 = 1'b0;
`ifdef LFSR_RESEED_EN
    seed = 8'd0; seed_we = 1'b0; seed8 = 8'd0; seed_we8 = 1'b0;
`endif
    @(negedge clk);
    do_reset();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rnd", 32'(rnd), 32'h2A);

    repeat (2) @(negedge clk);
    chk("idle_rnd_hold", 32'(rnd), 32'h2A);
    chk("idle_busy", 32'(busy), 32'd0);

    // Single draw with back-pressure; req dropped after grant must not cancel.
    sb_q.push_back('{gnt: 4'b0001, rnd: 8'h54});
    req = 4'b0001;
    @(negedge clk);
    chk("draw_gnt", 32'(gnt), 32'h1);
    chk("draw_busy", 32'(busy), 32'd1);
    chk("draw_valid_early", 32'(valid), 32'd0);
    req = 4'd0;
    @(negedge clk);
    chk("draw_latency_valid", 32'(valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(valid), 32'd1);
      chk("bp_gnt", 32'(gnt), 32'h1);
      chk("bp_rnd", 32'(rnd), 32'h54);
    end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("ack_valid", 32'(valid), 32'd0);
    chk("ack_gnt", 32'(gnt), 32'd0);
    chk("ack_busy", 32'(busy), 32'd0);
    chk("ack_rnd_hold", 32'(rnd), 32'h54);

    // Pointer now at 1; lone req on 0 must wrap around to it.
    sb_q.push_back('{gnt: 4'b0001, rnd: 8'hA9});
    req = 4'b0001;
    @(negedge clk);
    req = 4'd0;
    wait_valid(10);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;

    // Round-robin with all requests held and ack held high.
    do_reset();
    stamps_q.delete();
    sb_q.push_back('{gnt: 4'b0001, rnd: 8'h54});
    sb_q.push_back('{gnt: 4'b0010, rnd: 8'hA9});
    sb_q.push_back('{gnt: 4'b0100, rnd: 8'h53});
    sb_q.push_back('{gnt: 4'b1000, rnd: 8'hA7});
    sb_q.push_back('{gnt: 4'b0001, rnd: 8'h4E});
    req = 4'b1111;
    ack = 1'b1;
    for (int i = 0; i < 5; i++) wait_valid(10);
    req = 4'd0;
    @(negedge clk);
    ack = 1'b0;
    chk("rr_end_gnt", 32'(gnt), 32'd0);
    chk("rr_end_busy", 32'(busy), 32'd0);
    chk("rr_count", 32'(stamps_q.size()), 32'd5);
    for (int i = 1; i < stamps_q.size(); i++)
      chk("rr_period", 32'(stamps_q[i] - stamps_q[i-1]), 32'd3);

    // Reset while in DELIVER: grant abandoned, LFSR back to seed.
    sb_q.push_back('{gnt: 4'b0010, rnd: 8'h9D});
    req = 4'b0010;
    @(negedge clk);
    req = 4'd0;
    wait_valid(10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstdlv_valid", 32'(valid), 32'd0);
    chk("rstdlv_gnt", 32'(gnt), 32'd0);
    chk("rstdlv_rnd", 32'(rnd), 32'h2A);

`ifdef LFSR_RESEED_EN
    seed = 8'h00;
    seed_we = 1'b1;
    @(negedge clk);
    seed_we = 1'b0;
    chk("reseed_rnd", 32'(rnd), 32'h01);
    sb_q.push_back('{gnt: 4'b0100, rnd: 8'h02});
    req = 4'b0100;
    @(negedge clk);
    req = 4'd0;
    chk("reseed_gnt", 32'(gnt), 32'h4);
    wait_valid(10);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
`endif

    // STEPS=8 instance: reset during the third STEP cycle.
    rst8 = 1'b1;
    repeat (2) @(negedge clk);
    rst8 = 1'b0;
    req8 = 4'b0001;
    @(negedge clk);
    chk("s8_gnt", 32'(gnt8), 32'h1);
    req8 = 4'd0;
    repeat (2) @(negedge clk);
    chk("s8_mid_rnd", 32'(rnd8), 32'hA9);
    chk("s8_mid_busy", 32'(busy8), 32'd1);
    rst8 = 1'b1;
    @(negedge clk);
    rst8 = 1'b0;
    chk("s8_rst_gnt", 32'(gnt8), 32'd0);
    chk("s8_rst_rnd", 32'(rnd8), 32'h2A);
    chk("s8_rst_valid", 32'(valid8), 32'd0);
    chk("s8_rst_busy", 32'(busy8), 32'd0);

    // STEPS=8 full draw: valid nine cycles after the request is sampled.
    req8 = 4'b0001;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      req8 = 4'd0;
    end while (valid8 !== 1'b1 && n < 40);
    chk("s8_latency", 32'(n), 32'd9);
    chk("s8_rnd", 32'(rnd8), 32'h77);
    ack8 = 1'b1;
    @(negedge clk);
    ack8 = 1'b0;
    chk("s8_ack_valid", 32'(valid8), 32'd0);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
